// File: rtl/cpu6_fetch_buffer_if.sv
// Fetch-stage bundle: imem req/ack channel, EX redirect, decode stall and the F-stage outputs.
interface cpu6_fetch_buffer_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            validF;
    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] instrF;

    modport master (
        input  redirect, redirect_pc, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, validF, pcF, instrF
    );

    modport slave (
        output redirect, redirect_pc, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, validF, pcF, instrF
    );
endinterface

// File: rtl/cpu6_fetch_buffer.sv
// Instruction fetch: owns the fetch PC, runs the imem req/ack handshake and buffers responses
// for decode. Define CPU6_FETCH_BYPASS_EN to present an ack into an empty buffer in the same cycle.
module cpu6_fetch_buffer #(
    parameter int unsigned          CPU6_XLEN = 32,
    parameter logic [CPU6_XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned          DEPTH     = 2
) (
    input  logic                clk,
    input  logic                reset,
    cpu6_fetch_buffer_if.master fb
);
    localparam int unsigned     XLEN = CPU6_XLEN;
    localparam int unsigned     AW   = $clog2(DEPTH);
    localparam int unsigned     CW   = AW + 1;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] redir_pc_c;
    logic            keep_c;
    logic            empty_c;
    logic            full_c;
    logic            bypass_c;
    logic            valid_c;
    logic            take_c;
    logic            pop_c;
    logic            push_c;
    logic [CW-1:0]   count_next_c;
    entry_t          head_c;

    // Handshake qualification, head selection and FIFO occupancy after this cycle
    always_comb begin
        redir_pc_c = fb.redirect_pc & ~XLEN'(3);
        keep_c     = fb.imem_ack && !fb.redirect && (state == REQ);
        empty_c    = (count == '0);
        full_c     = (count == CW'(DEPTH));
        bypass_c   = 1'b0;
`ifdef CPU6_FETCH_BYPASS_EN
        bypass_c   = keep_c && empty_c;
`endif
        valid_c    = !empty_c || bypass_c;
        head_c     = mem[rd_ptr];
        if (bypass_c) begin
            head_c.pc    = pc;
            head_c.instr = fb.imem_rdata;
        end
        take_c       = valid_c && !fb.stall && !fb.redirect;
        pop_c        = take_c && !empty_c;
        // A bypassed instruction consumed by decode never enters the FIFO
        push_c       = keep_c && !(bypass_c && take_c);
        count_next_c = count + CW'(push_c) - CW'(pop_c);
    end

    assign fb.imem_req  = (state != IDLE);
    assign fb.imem_addr = pc;
    assign fb.validF    = valid_c;
    assign fb.pcF       = valid_c ? head_c.pc : '0;
    assign fb.instrF    = valid_c ? head_c.instr : NOP;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            tgt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (fb.redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + AW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
                count <= count_next_c;
            end

            // req/addr stay frozen until ack; a redirect without ack parks in DROP
            case (state)
                IDLE: begin
                    if (fb.redirect) begin
                        pc    <= redir_pc_c;
                        state <= REQ;
                    end else if (!full_c) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (fb.imem_ack) begin
                        if (fb.redirect) begin
                            pc <= redir_pc_c;
                        end else begin
                            pc    <= pc + XLEN'(4);
                            state <= (count_next_c == CW'(DEPTH)) ? IDLE : REQ;
                        end
                    end else if (fb.redirect) begin
                        tgt   <= redir_pc_c;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (fb.imem_ack) begin
                        pc    <= fb.redirect ? redir_pc_c : tgt;
                        state <= REQ;
                    end else if (fb.redirect) begin
                        tgt <= redir_pc_c;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction storage carries no reset; occupancy gates every read
    always_ff @(posedge clk) begin
        if (reset && push_c) begin
            mem[wr_ptr].pc    <= pc;
            mem[wr_ptr].instr <= fb.imem_rdata;
        end
    end

    overflow_a : assert property (@(posedge clk) disable iff (!reset)
        !(push_c && full_c && !pop_c));
endmodule

// File: tb/tb_cpu6_fetch_buffer.sv
// Directed bench for cpu6_fetch_buffer: streaming, stall backpressure, delayed ack,
// redirect flush/discard, PC wrap and mid-handshake reset.
module tb_cpu6_fetch_buffer;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef CPU6_FETCH_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cpu6_fetch_buffer_if #(.XLEN(32)) bus ();
    assign bus.imem_rdata = bus.imem_addr ^ K;

    cpu6_fetch_buffer #(.CPU6_XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .fb    (bus)
    );

    // Leaves the DUT in its first post-reset (IDLE) cycle with all inputs low
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0; bus.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0; bus.imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", bus.imem_req); end
        checks++; if (bus.validF !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.validF); end
        checks++; if (bus.pcF !== 32'h0) begin errors++; $display("FAIL reset_pcF got %h expected 0", bus.pcF); end
        checks++; if (bus.instrF !== NOP) begin errors++; $display("FAIL reset_instr got %h expected %h", bus.instrF, NOP); end
        @(negedge clk);
        reset = 1'b1; bus.imem_ack = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.validF !== 1'b0) begin
            errors++; $display("FAIL release got req=%b addr=%h valid=%b expected 1/0/0", bus.imem_req, bus.imem_addr, bus.validF); end
    endtask

    task automatic test_latency();
        do_reset();
        @(negedge clk); bus.imem_ack = 1'b1; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
            errors++; $display("FAIL lat_req got req=%b addr=%h expected 1/0", bus.imem_req, bus.imem_addr); end
`ifdef CPU6_FETCH_BYPASS_EN
        checks++; if (bus.validF !== 1'b1 || bus.pcF !== 32'h0 || bus.instrF !== K) begin
            errors++; $display("FAIL lat_bypass got v=%b pc=%h ins=%h expected 1/0/%h", bus.validF, bus.pcF, bus.instrF, K); end
`else
        checks++; if (bus.validF !== 1'b0 || bus.instrF !== NOP) begin
            errors++; $display("FAIL lat_ackcycle got v=%b ins=%h expected 0/%h", bus.validF, bus.instrF, NOP); end
        @(negedge clk); bus.imem_ack = 1'b0; #1;
        checks++; if (bus.validF !== 1'b1 || bus.pcF !== 32'h0 || bus.instrF !== K) begin
            errors++; $display("FAIL lat_next got v=%b pc=%h ins=%h expected 1/0/%h", bus.validF, bus.pcF, bus.instrF, K); end
`endif
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        bus.imem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * k)) begin
                errors++; $display("FAIL stream_addr k=%0d got req=%b addr=%h expected 1/%h", k, bus.imem_req, bus.imem_addr, 32'(4 * k)); end
            exp_pc = 32'(4 * (k - LAT));
            if (k < LAT) begin
                checks++; if (bus.validF !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %b expected 0", bus.validF); end
            end else begin
                checks++; if (bus.validF !== 1'b1 || bus.pcF !== exp_pc || bus.instrF !== (exp_pc ^ K)) begin
                    errors++; $display("FAIL stream_out k=%0d got v=%b pc=%h ins=%h expected 1/%h/%h", k, bus.validF, bus.pcF, bus.instrF, exp_pc, exp_pc ^ K); end
            end
        end
    endtask

    // Continues the stream: addr 0x20 is the next request when stall rises
    task automatic test_stall();
        logic [31:0] held;
        logic [31:0] exp_pc;
        int acks;
        int got;
        held = 32'(32 - 4 * LAT);
        acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); bus.stall = 1'b1; #1;
            if (bus.imem_req === 1'b1 && bus.imem_ack === 1'b1) acks++;
            checks++; if (bus.validF !== 1'b1 || bus.pcF !== held) begin
                errors++; $display("FAIL stall_hold c=%0d got v=%b pc=%h expected 1/%h", c, bus.validF, bus.pcF, held); end
        end
        checks++; if (acks !== 2 - LAT) begin errors++; $display("FAIL stall_acks got %0d expected %0d", acks, 2 - LAT); end
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle got req=%b expected 0", bus.imem_req); end
        exp_pc = held;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk); bus.stall = 1'b0; #1;
            if (bus.validF === 1'b1) begin
                checks++; if (bus.pcF !== exp_pc || bus.instrF !== (exp_pc ^ K)) begin
                    errors++; $display("FAIL stall_resume got pc=%h ins=%h expected %h/%h", bus.pcF, bus.instrF, exp_pc, exp_pc ^ K); end
                exp_pc = exp_pc + 32'd4;
                got++;
            end
        end
        checks++; if (got !== 5) begin errors++; $display("FAIL stall_resume_timeout got %0d expected 5", got); end
    endtask

    task automatic test_delay();
        logic found;
        do_reset();
        @(negedge clk); bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h10; #1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.imem_ack    = (c == 3);
            bus.redirect    = (c == 1);
            bus.redirect_pc = 32'h200;
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
                errors++; $display("FAIL delay_hold c=%0d got req=%b addr=%h expected 1/10", c, bus.imem_req, bus.imem_addr); end
        end
        checks++; if (bus.validF !== 1'b0) begin errors++; $display("FAIL delay_discard got v=%b expected 0", bus.validF); end
        @(negedge clk); bus.imem_ack = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200 || bus.validF !== 1'b0) begin
            errors++; $display("FAIL delay_refetch got req=%b addr=%h v=%b expected 1/200/0", bus.imem_req, bus.imem_addr, bus.validF); end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk); bus.imem_ack = 1'b1; #1;
            if (bus.validF === 1'b1) begin
                found = 1'b1;
                checks++; if (bus.pcF !== 32'h200) begin errors++; $display("FAIL delay_first got pc=%h expected 200", bus.pcF); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL delay_timeout got none expected pc 200"); end
    endtask

    task automatic test_redirect_flush();
        logic found;
        // Full FIFO flushed from IDLE
        do_reset();
        bus.stall = 1'b1; bus.imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'h80; #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.validF !== 1'b1 || bus.pcF !== 32'h0) begin
            errors++; $display("FAIL flush_full got req=%b v=%b pc=%h expected 0/1/0", bus.imem_req, bus.validF, bus.pcF); end
        @(negedge clk); bus.redirect = 1'b0; bus.stall = 1'b0; bus.imem_ack = 1'b0; #1;
        checks++; if (bus.validF !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin
            errors++; $display("FAIL flush_full_after got v=%b req=%b addr=%h expected 0/1/80", bus.validF, bus.imem_req, bus.imem_addr); end
        // Redirect coincident with the ack for 0x10
        do_reset();
        bus.imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        @(negedge clk); bus.redirect = 1'b1; bus.redirect_pc = 32'h80; bus.stall = 1'b1; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++; $display("FAIL flush_ack_addr got req=%b addr=%h expected 1/10", bus.imem_req, bus.imem_addr); end
        @(negedge clk); bus.redirect = 1'b0; bus.stall = 1'b0; bus.imem_ack = 1'b0; #1;
        checks++; if (bus.validF !== 1'b0 || bus.imem_addr !== 32'h80) begin
            errors++; $display("FAIL flush_ack_after got v=%b addr=%h expected 0/80", bus.validF, bus.imem_addr); end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk); bus.imem_ack = 1'b1; #1;
            if (bus.validF === 1'b1) begin
                found = 1'b1;
                checks++; if (bus.pcF !== 32'h80) begin errors++; $display("FAIL flush_first got pc=%h expected 80", bus.pcF); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL flush_timeout got none expected pc 80"); end
    endtask

    task automatic test_double_redirect();
        logic found;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.redirect    = (c < 2);
            bus.redirect_pc = (c == 0) ? 32'h300 : 32'h400;
            bus.imem_ack    = (c == 2);
            #1;
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
                errors++; $display("FAIL drop_hold c=%0d got req=%b addr=%h expected 1/0", c, bus.imem_req, bus.imem_addr); end
        end
        @(negedge clk); bus.imem_ack = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h400) begin
            errors++; $display("FAIL drop_resume got req=%b addr=%h expected 1/400", bus.imem_req, bus.imem_addr); end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk); bus.imem_ack = 1'b1; #1;
            if (bus.validF === 1'b1) begin
                found = 1'b1;
                checks++; if (bus.pcF !== 32'h400) begin errors++; $display("FAIL drop_first got pc=%h expected 400", bus.pcF); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL drop_timeout got none expected pc 400"); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        do_reset();
        @(negedge clk); bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFF; #1;
        @(negedge clk); bus.redirect = 1'b0; #1;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_align got %h expected fffffffc", bus.imem_addr); end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            exp_pc = 32'(4 * c - 4 * LAT);
            checks++; if (bus.imem_addr !== 32'(4 * c) || bus.validF !== 1'b1 || bus.pcF !== exp_pc) begin
                errors++; $display("FAIL wrap c=%0d got addr=%h v=%b pc=%h expected %h/1/%h", c, bus.imem_addr, bus.validF, bus.pcF, 32'(4 * c), exp_pc); end
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        @(negedge clk); bus.imem_ack = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h40; #1;
        @(negedge clk); bus.imem_ack = 1'b0; bus.redirect = 1'b0; #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
            errors++; $display("FAIL mid_wait got req=%b addr=%h expected 1/40", bus.imem_req, bus.imem_addr); end
        @(negedge clk); reset = 1'b0; bus.imem_ack = 1'b1;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.validF !== 1'b0) begin
            errors++; $display("FAIL mid_reset got req=%b v=%b expected 0/0", bus.imem_req, bus.validF); end
        @(negedge clk); reset = 1'b1; bus.imem_ack = 1'b0;
        @(negedge clk); #1;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.validF !== 1'b0) begin
            errors++; $display("FAIL mid_refetch got req=%b addr=%h v=%b expected 1/0/0", bus.imem_req, bus.imem_addr, bus.validF); end
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk); bus.imem_ack = 1'b1; #1;
            if (bus.validF === 1'b1) begin
                found = 1'b1;
                checks++; if (bus.pcF !== 32'h0 || bus.instrF !== K) begin
                    errors++; $display("FAIL mid_first got pc=%h ins=%h expected 0/%h", bus.pcF, bus.instrF, K); end
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL mid_timeout got none expected pc 0"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_stream();
        test_stall();
        test_delay();
        test_redirect_flush();
        test_double_redirect();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
